// File: rtl/xnor_frame_checker.sv
// Accumulates per-group 3-input XNOR values over FRAME_LEN groups and reports frame parity and
// mismatch flag on a valid/ready output. Define XNOR_FRAME_ERR_COUNT_EN to add the err_cnt port.
module xnor_frame_checker #(
    parameter int unsigned FRAME_LEN = 8,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             sof,
    input  logic             par_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             y,
    output logic             err,
`ifdef XNOR_FRAME_ERR_COUNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic [7:0]       grp_cnt
);

    if (FRAME_LEN < 2 || FRAME_LEN > 255 || CNT_W < 1) begin : g_param_check
        $error("xnor_frame_checker: illegal FRAME_LEN or CNT_W");
    end

    localparam logic [7:0] FrameCnt = 8'(FRAME_LEN);
    localparam logic [7:0] LastCnt  = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e     r_state;
    logic       r_acc;
    logic       r_y;
    logic       r_err;
    logic       r_out_valid;
    logic [7:0] r_grp_cnt;

    logic w_g;
    logic w_accept;

    assign w_g      = ~(a ^ b ^ c);
    assign in_ready = rst_n & (r_state != StHold);
    assign w_accept = in_valid & in_ready;

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign err       = r_err;
    assign grp_cnt   = r_grp_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_acc       <= 1'b0;
            r_y         <= 1'b0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
            r_grp_cnt   <= 8'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    // Groups without sof outside a frame are consumed and dropped.
                    if (w_accept && sof) begin
                        r_acc     <= w_g;
                        r_grp_cnt <= 8'd1;
                        r_state   <= StAcc;
                    end
                end
                StAcc: begin
                    if (w_accept) begin
                        if (sof) begin
                            r_acc     <= w_g;
                            r_grp_cnt <= 8'd1;
                        end else if (r_grp_cnt == LastCnt) begin
                            r_y         <= r_acc ^ w_g;
                            r_err       <= r_acc ^ w_g ^ par_in;
                            r_out_valid <= 1'b1;
                            r_grp_cnt   <= FrameCnt;
                            r_state     <= StHold;
                        end else begin
                            r_acc     <= r_acc ^ w_g;
                            r_grp_cnt <= r_grp_cnt + 8'd1;
                        end
                    end
                end
                StHold: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_grp_cnt   <= 8'd0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef XNOR_FRAME_ERR_COUNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    assign err_cnt = r_err_cnt;

    // Saturating count of error frames, bumped on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (r_out_valid && out_ready && r_err && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_xnor_frame_checker.sv
// Directed self-checking bench for xnor_frame_checker with FRAME_LEN=4 (CNT_W=2 for the
// optional XNOR_FRAME_ERR_COUNT_EN counter).
module tb_xnor_frame_checker;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic       a;
    logic       b;
    logic       c;
    logic       sof;
    logic       par_in;
    logic       out_valid;
    logic       out_ready;
    logic       y;
    logic       err;
    logic [7:0] grp_cnt;
`ifdef XNOR_FRAME_ERR_COUNT_EN
    logic [1:0] err_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    xnor_frame_checker #(
        .FRAME_LEN (4),
        .CNT_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .sof       (sof),
        .par_in    (par_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .err       (err),
`ifdef XNOR_FRAME_ERR_COUNT_EN
        .err_cnt   (err_cnt),
`endif
        .grp_cnt   (grp_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called #1 after a rising edge; presents one group for one edge.
    task automatic send_group(input logic [2:0] abc, input logic s, input logic p);
        {c, b, a} = abc;
        sof       = s;
        par_in    = p;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
        par_in   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = 0; b = 0; c = 0; sof = 0; par_in = 0; out_ready = 1'b1;
        #3;
        checks++;
        if ({out_valid, y, err, in_ready} !== 4'b0000 || grp_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_state: got ov/y/err/rdy=%b grp=%0d want 0000 grp=0",
                     {out_valid, y, err, in_ready}, grp_cnt);
        end
`ifdef XNOR_FRAME_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 2'd0) begin
            failures++;
            $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic_frame();
        out_ready = 1'b1;
        send_group(3'b000, 1'b1, 1'b0);
        checks++;
        if (grp_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_first_cnt: got %0d want 1", grp_cnt);
        end
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        checks++;
        if ({out_valid, y, err, in_ready} !== 4'b1000 || grp_cnt !== 8'd4) begin
            failures++;
            $display("FAIL basic_result: got ov/y/err/rdy=%b grp=%0d want 1000 grp=4",
                     {out_valid, y, err, in_ready}, grp_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || grp_cnt !== 8'd0) begin
            failures++;
            $display("FAIL basic_return_idle: got ov/rdy=%b grp=%0d want 01 grp=0",
                     {out_valid, in_ready}, grp_cnt);
        end
    endtask

    task automatic test_error_frame();
        // g = 0,1,1,1 -> y=1; par_in=0 -> err=1
        send_group(3'b001, 1'b1, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        checks++;
        if ({out_valid, y, err} !== 3'b111) begin
            failures++;
            $display("FAIL error_result: got ov/y/err=%b want 111", {out_valid, y, err});
        end
`ifdef XNOR_FRAME_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 2'd0) begin
            failures++;
            $display("FAIL error_cnt_before: got %0d want 0", err_cnt);
        end
`endif
        @(posedge clk); #1;
`ifdef XNOR_FRAME_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 2'd1) begin
            failures++;
            $display("FAIL error_cnt_after: got %0d want 1", err_cnt);
        end
`endif
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL error_handshake: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        // g = 1,1,1,1 -> y=0; par_in=1 -> err=1
        send_group(3'b000, 1'b1, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            {c, b, a} = 3'b111; sof = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, y, err, in_ready} !== 4'b1010 || grp_cnt !== 8'd4) begin
                failures++;
                $display("FAIL backpressure_hold[%0d]: got ov/y/err/rdy=%b grp=%0d want 1010 grp=4",
                         i, {out_valid, y, err, in_ready}, grp_cnt);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; sof = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || grp_cnt !== 8'd0) begin
            failures++;
            $display("FAIL backpressure_release: got ov/rdy=%b grp=%0d want 01 grp=0",
                     {out_valid, in_ready}, grp_cnt);
        end
`ifdef XNOR_FRAME_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 2'd2) begin
            failures++;
            $display("FAIL backpressure_err_cnt: got %0d want 2", err_cnt);
        end
`endif
    endtask

    task automatic test_restart();
        send_group(3'b000, 1'b1, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b111, 1'b1, 1'b0);
        checks++;
        if (grp_cnt !== 8'd1) begin
            failures++;
            $display("FAIL restart_cnt: got %0d want 1", grp_cnt);
        end
        // g = 0,1,1,1 -> y=1; par_in=1 -> err=0
        send_group(3'b011, 1'b0, 1'b0);
        send_group(3'b011, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || grp_cnt !== 8'd3) begin
            failures++;
            $display("FAIL restart_midframe: got ov=%b grp=%0d want ov=0 grp=3", out_valid, grp_cnt);
        end
        send_group(3'b000, 1'b0, 1'b1);
        checks++;
        if ({out_valid, y, err} !== 3'b110 || grp_cnt !== 8'd4) begin
            failures++;
            $display("FAIL restart_result: got ov/y/err=%b grp=%0d want 110 grp=4",
                     {out_valid, y, err}, grp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_discard_and_reset();
        send_group(3'b000, 1'b0, 1'b0);
        checks++;
        if (grp_cnt !== 8'd0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL discard_idle: got grp=%0d ov=%b want grp=0 ov=0", grp_cnt, out_valid);
        end
        send_group(3'b000, 1'b1, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        checks++;
        if (grp_cnt !== 8'd2) begin
            failures++;
            $display("FAIL discard_pre_reset: got grp=%0d want 2", grp_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, y, err, in_ready} !== 4'b0000 || grp_cnt !== 8'd0) begin
            failures++;
            $display("FAIL async_reset: got ov/y/err/rdy=%b grp=%0d want 0000 grp=0",
                     {out_valid, y, err, in_ready}, grp_cnt);
        end
`ifdef XNOR_FRAME_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 2'd0) begin
            failures++;
            $display("FAIL async_reset_err_cnt: got %0d want 0", err_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        // g = 0,1,1,1 -> y=1; par_in=1 -> err=0
        send_group(3'b111, 1'b1, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b0);
        send_group(3'b000, 1'b0, 1'b1);
        checks++;
        if ({out_valid, y, err} !== 3'b110 || grp_cnt !== 8'd4) begin
            failures++;
            $display("FAIL post_reset_frame: got ov/y/err=%b grp=%0d want 110 grp=4",
                     {out_valid, y, err}, grp_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            send_group(3'b001, 1'b1, 1'b0);
            send_group(3'b000, 1'b0, 1'b0);
            send_group(3'b000, 1'b0, 1'b0);
            send_group(3'b000, 1'b0, 1'b0);
            checks++;
            if ({out_valid, y, err} !== 3'b111) begin
                failures++;
                $display("FAIL sat_frame[%0d]: got ov/y/err=%b want 111", i, {out_valid, y, err});
            end
            @(posedge clk); #1;
`ifdef XNOR_FRAME_ERR_COUNT_EN
            checks++;
            if (err_cnt !== exp_cnt[i]) begin
                failures++;
                $display("FAIL sat_err_cnt[%0d]: got %0d want %0d", i, err_cnt, exp_cnt[i]);
            end
`else
            if (exp_cnt[i] == 2'd0) $display("unexpected table entry");
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_error_frame();
        test_backpressure();
        test_restart();
        test_discard_and_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
